bulls_cows_game_ctrl: RTL
=========================

Name: bulls_cows_game_ctrl

Overview:
- Game sequencer for the two-player Bulls & Cows game on the Nexys A7.
- Conditions the confirm button, accepts each player's 4-digit hex secret from SW[15:0], then alternates guesses, scores each guess and drives the eight display digit fields.
- Outputs feed dspl_drv_NexysA7 directly.
- Replaces the ad-hoc game sequencing inside display_manager.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable clock samples required before the synchronized confirm level is accepted.
- ATTEMPT_W, 8, width of each player's attempt counter.

Ports:
- clock  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- confirm  in  1  raw centre pushbutton, asynchronous to clock.
- SW  in  16  digit entry; SW[15:12] is digit 3 (leftmost), SW[3:0] is digit 0.
- d1..d8  out  6 each  display fields, format {enable, value[3:0], dp}; d8 is the leftmost digit.
- game_state  out  enum  current FSM state, for LEDs/debug.
- entry_err  out  1  high while the last confirmed entry was rejected.

Behaviour:
- One clock; reset is synchronous and active-high. All state is registered.
- Reset values:
  - state SECRET_J1.
  - Both secrets 0x0000; guess register 0.
  - Both attempt counters 0; bulls and cows 0; entry_err 0.
  - d1..d8 = 6'b0 (blank).
- Confirm conditioning:
  - Two-flop synchronizer, then debounce counter; the debounced level changes only after DEBOUNCE_CYCLES equal consecutive samples.
  - Rising edge of the debounced level produces a single-cycle confirm_evt.
  - Holding the button yields exactly one event. A glitch shorter than DEBOUNCE_CYCLES yields none.
- Entry validity: the 4 nibbles of SW must be pairwise distinct (0x0–0xF allowed).
  - Invalid entry: confirm_evt is ignored for state purposes, entry_err is set, and the state is held.
  - The next valid confirm clears entry_err.
- States and transitions (transitions occur only on confirm_evt unless noted):
  - SECRET_J1 -> SECRET_J2: latch sec1 = SW.
  - SECRET_J2 -> GUESS_J1: latch sec2 = SW. sec2 may equal sec1.
  - GUESS_Jn -> SCORE: latch guess = SW, set active player n, increment att_n. att_n saturates at 2^ATTEMPT_W-1 and does not wrap.
  - SCORE: waits for the scorer valid (fixed 1 cycle), then:
    - bulls == 4 -> WIN.
    - otherwise -> RESULT_Jn.
  - RESULT_J1 -> GUESS_J2; RESULT_J2 -> GUESS_J1.
  - WIN -> SECRET_J1: clears secrets, counters and err.
- Scoring targets: J1 guesses sec2; J2 guesses sec1.
  - bulls = count of positions where guess nibble == secret nibble.
  - cows = count of guess nibbles present in the secret at a different position.
  - Both fit in 3 bits. Range 0..4, bulls+cows ≤ 4.
- confirm_evt in SCORE is dropped. reset in any state returns to the reset values on the next edge.
- Display outputs are registered from the current state, so the display lags the state by 1 cycle. Unlisted digits are blank.
  - SECRET_Jn: d8 = n with dp = 1; d4..d1 = live SW.
  - GUESS_Jn: d8 = n; d7..d6 = att_n in hex, high nibble first; d4..d1 = live SW.
  - RESULT_Jn: d8 = n; d7 = bulls with dp = 1; d6 = cows; d4..d1 = latched guess.
  - WIN: d8 = winner with dp = 1; d7..d6 = winner's attempts; d4..d1 = the guessed secret.
- Secrets are never displayed except in WIN.

Decomposition:
- bulls_cows_pkg:
  - state_t with states SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2, SCORE, RESULT_J1, RESULT_J2, WIN.
  - digit_t (6-bit display field).
  - DIG_BLANK constant.
  - Functions mk_digit(val, dp) and digits_distinct(logic[15:0]).
- Sub-module bulls_cows_score: registered scorer.
  - Inputs: start, guess[15:0], secret[15:0].
  - Outputs: valid, bulls[2:0], cows[2:0].
  - Latency 1 cycle; valid is a 1-cycle pulse.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
1. Reset, then confirm held 20 cycles with SW = 0x1234 -> exactly one confirm_evt; state SECRET_J2; d8 = {1,2,1}. A 3-cycle pulse causes no transition.
2. Secrets sec1 = 0x1234, sec2 = 0x5678; J1 guesses 0x5687 -> RESULT_J1 with bulls = 2, cows = 2; d7 = {1,2,1}, d6 = {1,2,0}, att1 = 1.
3. SW = 0x1123 confirmed in SECRET_J1 or GUESS_J2 -> entry_err = 1, state unchanged, attempt counter unchanged. Then 0x1203 confirmed -> entry_err = 0 and the state advances.
4. J2 guesses 0x1234 against sec1 = 0x1234 -> SCORE then WIN; d8 = {1,2,1}; d4..d1 = 1,2,3,4. Next confirm -> SECRET_J1 with all counters 0.
5. Force att1 = 0xFF via repeated misses (or a backdoor) and guess again -> att1 stays 0xFF.
6. Assert reset for 1 cycle while in RESULT_J2 -> next cycle state SECRET_J1; one cycle later all fields match the SECRET_J1 display (d8 = {1,1,1}); entry_err = 0.

Source files
------------

// File: rtl/bulls_cows_pkg.sv
// Shared types and helpers for the Bulls & Cows game controller.
// Display field format is {enable, value[3:0], dp}.
package bulls_cows_pkg;

  typedef enum logic [2:0] {
    SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2, SCORE, RESULT_J1, RESULT_J2, WIN
  } state_t;

  typedef logic [5:0] digit_t;

  localparam digit_t DIG_BLANK = 6'b0;

  function automatic digit_t mk_digit(input logic [3:0] val, input logic dp);
    return {1'b1, val, dp};
  endfunction

  function automatic logic digits_distinct(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bulls_cows_score.sv
// Registered bulls/cows scorer: result and a 1-cycle valid pulse one clock after start.
// No backpressure; results hold until the next start.
module bulls_cows_score (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] guess,
  input  logic [15:0] secret,
  output logic        valid,
  output logic [2:0]  bulls,
  output logic [2:0]  cows
);

  logic [2:0] bulls_nxt;
  logic [2:0] cows_nxt;
  logic       hit;

  always_comb begin
    bulls_nxt = 3'd0;
    cows_nxt  = 3'd0;
    hit       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      if (guess[4*i +: 4] == secret[4*i +: 4]) begin
        bulls_nxt = bulls_nxt + 3'd1;
      end else begin
        for (int j = 0; j < 4; j++)
          if (j != i && guess[4*i +: 4] == secret[4*j +: 4]) hit = 1'b1;
        if (hit) cows_nxt = cows_nxt + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      bulls <= 3'd0;
      cows  <= 3'd0;
    end else begin
      valid <= start;
      if (start) begin
        bulls <= bulls_nxt;
        cows  <= cows_nxt;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Bulls & Cows game sequencer: debounced confirm, secret/guess entry, scoring and display fields.
// Display lags state by one cycle; confirm presses arriving in SCORE are dropped.
module bulls_cows_game_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ATTEMPT_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        confirm,
  input  logic [15:0] SW,
  output digit_t      d1,
  output digit_t      d2,
  output digit_t      d3,
  output digit_t      d4,
  output digit_t      d5,
  output digit_t      d6,
  output digit_t      d7,
  output digit_t      d8,
  output state_t      game_state,
  output logic        entry_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  state_t               state, state_nxt;
  logic                 sync1, sync2, deb_level, deb_level_q, confirm_evt;
  logic [CW-1:0]        deb_cnt;
  logic [15:0]          sec1, sec2, guess;
  logic                 player;
  logic [ATTEMPT_W-1:0] att1, att2;
  logic                 entry_state, accept, reject, score_start, score_valid;
  logic [2:0]           bulls, cows;
  digit_t [8:1]         disp, disp_nxt;
  logic [7:0]           att_show;
  logic [15:0]          val_show;
  logic                 show_low;

  // Confirm conditioning: 2-flop sync, then level accepted after N equal samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb_level   <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync1       <= confirm;
      sync2       <= sync1;
      deb_level_q <= deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign confirm_evt = deb_level & ~deb_level_q;

  assign entry_state = (state == SECRET_J1) || (state == SECRET_J2) ||
                       (state == GUESS_J1)  || (state == GUESS_J2);
  assign accept      = confirm_evt && entry_state && digits_distinct(SW);
  assign reject      = confirm_evt && entry_state && !digits_distinct(SW);
  assign score_start = accept && ((state == GUESS_J1) || (state == GUESS_J2));

  bulls_cows_score u_score (
    .clock  (clock),
    .reset  (reset),
    .start  (score_start),
    .guess  (SW),
    .secret ((state == GUESS_J1) ? sec2 : sec1),
    .valid  (score_valid),
    .bulls  (bulls),
    .cows   (cows)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= SECRET_J1;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SECRET_J1: if (accept) state_nxt = SECRET_J2;
      SECRET_J2: if (accept) state_nxt = GUESS_J1;
      GUESS_J1,
      GUESS_J2:  if (accept) state_nxt = SCORE;
      SCORE:     if (score_valid)
                   state_nxt = (bulls == 3'd4) ? WIN : (player ? RESULT_J2 : RESULT_J1);
      RESULT_J1: if (confirm_evt) state_nxt = GUESS_J2;
      RESULT_J2: if (confirm_evt) state_nxt = GUESS_J1;
      WIN:       if (confirm_evt) state_nxt = SECRET_J1;
      default:   state_nxt = SECRET_J1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sec1      <= '0;
      sec2      <= '0;
      guess     <= '0;
      player    <= 1'b0;
      att1      <= '0;
      att2      <= '0;
      entry_err <= 1'b0;
    end else begin
      if (reject) entry_err <= 1'b1;
      if (accept) begin
        entry_err <= 1'b0;
        case (state)
          SECRET_J1: sec1 <= SW;
          SECRET_J2: sec2 <= SW;
          GUESS_J1: begin
            guess  <= SW;
            player <= 1'b0;
            if (att1 != '1) att1 <= att1 + 1'b1;
          end
          GUESS_J2: begin
            guess  <= SW;
            player <= 1'b1;
            if (att2 != '1) att2 <= att2 + 1'b1;
          end
          default: ;
        endcase
      end
      if (state == WIN && confirm_evt) begin
        sec1      <= '0;
        sec2      <= '0;
        att1      <= '0;
        att2      <= '0;
        entry_err <= 1'b0;
      end
    end
  end

  always_comb begin
    disp_nxt = '0;
    att_show = (state == GUESS_J2 || (state == WIN && player)) ? 8'(att2) : 8'(att1);
    val_show = SW;
    show_low = 1'b0;
    case (state)
      SECRET_J1, SECRET_J2: begin
        disp_nxt[8] = mk_digit((state == SECRET_J2) ? 4'd2 : 4'd1, 1'b1);
        show_low    = 1'b1;
      end
      GUESS_J1, GUESS_J2: begin
        disp_nxt[8] = mk_digit((state == GUESS_J2) ? 4'd2 : 4'd1, 1'b0);
        disp_nxt[7] = mk_digit(att_show[7:4], 1'b0);
        disp_nxt[6] = mk_digit(att_show[3:0], 1'b0);
        show_low    = 1'b1;
      end
      RESULT_J1, RESULT_J2: begin
        disp_nxt[8] = mk_digit((state == RESULT_J2) ? 4'd2 : 4'd1, 1'b0);
        disp_nxt[7] = mk_digit({1'b0, bulls}, 1'b1);
        disp_nxt[6] = mk_digit({1'b0, cows}, 1'b0);
        val_show    = guess;
        show_low    = 1'b1;
      end
      WIN: begin
        disp_nxt[8] = mk_digit(player ? 4'd2 : 4'd1, 1'b1);
        disp_nxt[7] = mk_digit(att_show[7:4], 1'b0);
        disp_nxt[6] = mk_digit(att_show[3:0], 1'b0);
        val_show    = guess;
        show_low    = 1'b1;
      end
      default: ;
    endcase
    if (show_low)
      for (int k = 0; k < 4; k++) disp_nxt[k+1] = mk_digit(val_show[4*k +: 4], 1'b0);
  end

  always_ff @(posedge clock) begin
    if (reset) disp <= {8{DIG_BLANK}};
    else       disp <= disp_nxt;
  end

  assign {d8, d7, d6, d5, d4, d3, d2, d1} = disp;
  assign game_state = state;

endmodule
